// File: rtl/piano_pkg.sv
// Shared types for the piano datapath: key/chord vector width and helpers.
// The divider stage imports this too, so chord widths match by construction.
package piano_pkg;

  localparam int N_KEYS = 8;

  typedef logic [N_KEYS-1:0] key_vec_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-FF synchroniser, tick-driven stability counter, debounced level
// and one-cycle press/release pulses.
module key_debounce_bit
  import piano_pkg::*;
#(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic on,
  output logic off
);

  localparam int             DW   = cnt_width(STABLE_TICKS);
  localparam logic [DW-1:0]  LAST = DW'(STABLE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_dcnt;
  logic          r_level;
  logic          r_on;
  logic          r_off;

  // NOTE: every register here uses <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dcnt  <= '0;
      r_level <= 1'b0;
      r_on    <= 1'b0;
      r_off   <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_on    <= 1'b0;
      r_off   <= 1'b0;
      if (tick) begin
        if (r_sync2 == r_level) begin
          r_dcnt <= '0;
        end else if (r_dcnt == LAST) begin
          // Counter stops at LAST and clears on acceptance, so it never wraps.
          r_level <= r_sync2;
          r_dcnt  <= '0;
          r_on    <= r_sync2;
          r_off   <= ~r_sync2;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end
  end

  assign level = r_level;
  assign on    = r_on;
  assign off   = r_off;

endmodule

// File: rtl/key_debounce.sv
// Piano front end: shared debounce prescaler plus one debouncer per key,
// producing a clean chord vector and press/release/change strobes.
module key_debounce
  import piano_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic     clk,
  input  logic     rst,
  input  key_vec_t keys_raw,
  output key_vec_t chord,
  output key_vec_t key_on,
  output key_vec_t key_off,
  output logic     chord_chg
);

  localparam int            PW     = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;
  key_vec_t      w_level;
  key_vec_t      w_on;
  key_vec_t      w_off;

  // With TICK_DIV=1 the counter is pinned at 0 and the tick is always high.
  assign w_tick = (r_pcnt == P_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick),
      .raw  (keys_raw[i]),
      .level(w_level[i]),
      .on   (w_on[i]),
      .off  (w_off[i])
    );
  end

  assign chord   = w_level;
  assign key_on  = w_on;
  assign key_off = w_off;

  // Reduced from the per-key pulse registers, so it shares their cycle and has no input path.
  assign chord_chg = |(w_on | w_off);

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench: two debouncer configurations driven by the same keys,
// compared every cycle against a tick-history reference model plus directed checks.
module tb_key_debounce;
  import piano_pkg::*;

  localparam int TD_A = 4;
  localparam int ST_A = 3;
  localparam int TD_B = 1;
  localparam int ST_B = 1;

  logic     clk = 1'b0;
  logic     rst;
  key_vec_t keys_raw;

  key_vec_t chord_a, key_on_a, key_off_a;
  logic     chord_chg_a;
  key_vec_t chord_b, key_on_b, key_off_b;
  logic     chord_chg_b;

  key_debounce #(.TICK_DIV(TD_A), .STABLE_TICKS(ST_A)) u_dut_a (
    .clk(clk), .rst(rst), .keys_raw(keys_raw),
    .chord(chord_a), .key_on(key_on_a), .key_off(key_off_a), .chord_chg(chord_chg_a)
  );

  key_debounce #(.TICK_DIV(TD_B), .STABLE_TICKS(ST_B)) u_dut_b (
    .clk(clk), .rst(rst), .keys_raw(keys_raw),
    .chord(chord_b), .key_on(key_on_b), .key_off(key_off_b), .chord_chg(chord_chg_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each key remembers the synchronised level it saw on every
  // tick since its last change; a new level is accepted once the latest
  // STABLE_TICKS samples all differ from the current chord bit.
  key_vec_t    m_s1[2], m_s2[2], m_chord[2], m_on[2], m_off[2];
  int          m_phase[2];
  logic [31:0] m_hist[2][N_KEYS];
  int          m_n[2][N_KEYS];

  task automatic model_step(input int d, input int td, input int st,
                            input logic r, input key_vec_t raw);
    logic [31:0] mask;
    logic [31:0] want;
    if (r) begin
      m_phase[d] = 0;
      m_s1[d] = '0; m_s2[d] = '0; m_chord[d] = '0; m_on[d] = '0; m_off[d] = '0;
      for (int k = 0; k < N_KEYS; k++) begin
        m_hist[d][k] = '0;
        m_n[d][k]    = 0;
      end
    end else begin
      m_on[d]  = '0;
      m_off[d] = '0;
      if ((m_phase[d] % td) == td - 1) begin
        mask = (32'd1 << st) - 32'd1;
        for (int k = 0; k < N_KEYS; k++) begin
          m_hist[d][k] = {m_hist[d][k][30:0], m_s2[d][k]};
          if (m_n[d][k] < 32) m_n[d][k]++;
          want = {32{~m_chord[d][k]}};
          if (m_n[d][k] >= st && ((m_hist[d][k] ^ want) & mask) == 32'd0) begin
            m_chord[d][k] = m_s2[d][k];
            if (m_s2[d][k]) m_on[d][k] = 1'b1;
            else            m_off[d][k] = 1'b1;
            m_n[d][k] = 0;
          end
        end
      end
      m_phase[d]++;
      m_s2[d] = m_s1[d];
      m_s1[d] = raw;
    end
  endtask

  // Consecutive most-recent tick samples that disagree with the model chord bit.
  function automatic int run_len(input int d, input int k);
    int r = 0;
    for (int b = 0; b < m_n[d][k] && b < 32; b++) begin
      if (m_hist[d][k][b] != m_chord[d][k]) r++;
      else break;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    model_step(0, TD_A, ST_A, rst, keys_raw);
    model_step(1, TD_B, ST_B, rst, keys_raw);
  end

  bit       chk_en = 1'b0;
  key_vec_t acc_on, acc_off;
  int       acc_chg, acc_on3, acc_hi3, acc_a1, acc_b1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_chord",   chord_a,     m_chord[0]);
      check("a_key_on",  key_on_a,    m_on[0]);
      check("a_key_off", key_off_a,   m_off[0]);
      check("a_chg",     chord_chg_a, |(m_on[0] | m_off[0]));
      check("b_chord",   chord_b,     m_chord[1]);
      check("b_key_on",  key_on_b,    m_on[1]);
      check("b_key_off", key_off_b,   m_off[1]);
      check("b_chg",     chord_chg_b, |(m_on[1] | m_off[1]));
      acc_on  |= key_on_a;
      acc_off |= key_off_a;
      acc_chg += int'(chord_chg_a);
      acc_on3 += int'(key_on_a[3]);
      acc_hi3 += int'(chord_a[3]);
      acc_a1  += int'(chord_a[1]);
      acc_b1  += int'(chord_b[1]);
    end
  end

  task automatic clear_acc();
    acc_on = '0; acc_off = '0;
    acc_chg = 0; acc_on3 = 0; acc_hi3 = 0; acc_a1 = 0; acc_b1 = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input key_vec_t v);
    keys_raw = v;
    cyc(24);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_acc();
    rst      = 1'b1;
    keys_raw = '1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    keys_raw = '0;
    cyc(1);
    check("rst_chord",   chord_a,   8'h00);
    check("rst_key_on",  key_on_a,  8'h00);
    check("rst_chg",     chord_chg_a, 1'b0);

    // Clean single press.
    settle(8'h00);
    clear_acc();
    keys_raw = 8'h01;
    cyc(17);
    check("press_chord_in_time", chord_a, 8'h01);
    cyc(7);
    check("press_key_on",  acc_on,  8'h01);
    check("press_key_off", acc_off, 8'h00);
    check("press_chg_cnt", acc_chg, 1);

    // Bouncing key 3: never stable for three ticks until it is held.
    settle(8'h00);
    clear_acc();
    for (int t = 0; t < 8; t++) begin
      keys_raw[3] = ~keys_raw[3];
      cyc(5);
    end
    check("bounce_held_low", acc_hi3, 0);
    keys_raw[3] = 1'b1;
    cyc(24);
    check("bounce_chord",  chord_a[3], 1'b1);
    check("bounce_on_cnt", acc_on3,    1);

    // Multi-key chord and a mixed press/release on one edge.
    settle(8'h00);
    clear_acc();
    keys_raw = 8'h15;
    cyc(24);
    check("chord_value",   chord_a, 8'h15);
    check("chord_key_on",  acc_on,  8'h15);
    check("chord_key_off", acc_off, 8'h00);
    check("chord_chg_cnt", acc_chg, 1);
    clear_acc();
    keys_raw = 8'h0C;
    cyc(24);
    check("mix_value",   chord_a, 8'h0C);
    check("mix_key_on",  acc_on,  8'h08);
    check("mix_key_off", acc_off, 8'h11);
    check("mix_chg_cnt", acc_chg, 1);

    // Reset after two qualifying ticks discards the partial debounce.
    settle(8'h00);
    keys_raw = 8'h80;
    for (n = 0; n < 20; n++) begin
      cyc(1);
      if (run_len(0, 7) == 2) break;
    end
    check("mid_two_ticks_reached", n < 20, 1'b1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_chord", chord_a, 8'h00);
    for (n = 1; n <= 20; n++) begin
      cyc(1);
      if (chord_a[7]) break;
    end
    check("mid_requal_cycles", n, 12);

    // One-cycle glitch: accepted by the fast variant, rejected by the slow one.
    settle(8'h00);
    clear_acc();
    keys_raw[1] = 1'b1;
    cyc(1);
    keys_raw[1] = 1'b0;
    cyc(10);
    check("glitch_b_high_cycles", acc_b1, 1);
    check("glitch_a_high_cycles", acc_a1, 0);

    // Random key patterns with random hold times.
    for (int i = 0; i < 60; i++) begin
      keys_raw = key_vec_t'($urandom);
      cyc(int'($urandom_range(1, 24)));
    end
    settle(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
